// File: rtl/sram_responder_if.sv
// Bundle of the core-facing instruction and data SRAM ports plus the sticky error flags.
// The core drives the master side; sram_responder sits on the slave side.
interface sram_responder_if;
    logic        inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        addr_err;
    logic        inst_we_err;

    modport master (
        output inst_sram_we, inst_sram_addr, inst_sram_wdata,
        input  inst_sram_rdata,
        output data_sram_we, data_sram_addr, data_sram_wdata,
        input  data_sram_rdata,
        input  addr_err, inst_we_err
    );

    modport slave (
        input  inst_sram_we, inst_sram_addr, inst_sram_wdata,
        output inst_sram_rdata,
        input  data_sram_we, data_sram_addr, data_sram_wdata,
        output data_sram_rdata,
        output addr_err, inst_we_err
    );
endinterface

// File: rtl/sram_responder.sv
// Far-end responder for the core's inst/data SRAM ports: word storage, fixed read latency,
// sticky error flags. Define SRAM_TIMER_EN to map a free-running cycle timer at TIMER_ADDR.
module sram_responder #(
    parameter logic [31:0] ADDR_BASE  = 32'h1c00_0000,
    parameter int          DEPTH_LOG2 = 14,
    parameter int          RD_LATENCY = 1,
    parameter string       INIT_FILE  = "",
    parameter logic [31:0] TIMER_ADDR = 32'hbfaf_e000
) (
    input logic             clk,
    input logic             reset,
    sram_responder_if.slave sram
);

    localparam int          DEPTH = 1 << DEPTH_LOG2;
    localparam logic [32:0] SPAN  = 33'(1) << (DEPTH_LOG2 + 2);

    logic [31:0] mem_q [DEPTH];

    logic [31:0]           instOff;
    logic [31:0]           dataOff;
    logic                  instInRange;
    logic                  dataInRange;
    logic [DEPTH_LOG2-1:0] instIdx;
    logic [DEPTH_LOG2-1:0] dataIdx;
    logic                  unusedInstWdata;

    // Offsets wrap, so addresses below ADDR_BASE land far out of range.
    assign instOff     = sram.inst_sram_addr - ADDR_BASE;
    assign dataOff     = sram.data_sram_addr - ADDR_BASE;
    assign instInRange = {1'b0, instOff} < SPAN;
    assign dataInRange = {1'b0, dataOff} < SPAN;
    assign instIdx     = instOff[DEPTH_LOG2+1:2];
    assign dataIdx     = dataOff[DEPTH_LOG2+1:2];
    assign unusedInstWdata = ^sram.inst_sram_wdata;

    logic        timerHit;
    logic [31:0] timerVal;

`ifdef SRAM_TIMER_EN
    logic [31:0] timer_q;
    logic [31:0] timer_d;

    assign timerHit = (sram.data_sram_addr == TIMER_ADDR);

    always_comb begin
        timer_d = timer_q + 32'd1;
        if (timerHit && sram.data_sram_we) begin
            timer_d = sram.data_sram_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    // A read returns the value the counter takes at its sampling edge.
    assign timerVal = timer_d;
`else
    assign timerHit = 1'b0;
    assign timerVal = '0;
`endif

    logic memWe;
    assign memWe = !reset && sram.data_sram_we && dataInRange && !timerHit;

    always_ff @(posedge clk) begin
        if (memWe) begin
            mem_q[dataIdx] <= sram.data_sram_wdata;
        end
    end

    logic [31:0] instPipe_q [RD_LATENCY];
    logic [31:0] instPipe_d [RD_LATENCY];
    logic [31:0] dataPipe_q [RD_LATENCY];
    logic [31:0] dataPipe_d [RD_LATENCY];

    // Stage 0 captures the pre-write word, giving read-before-write on both ports.
    always_comb begin
        for (int s = 0; s < RD_LATENCY; s++) begin
            instPipe_d[s] = '0;
            dataPipe_d[s] = '0;
        end
        instPipe_d[0] = instInRange ? mem_q[instIdx] : '0;
        if (timerHit) begin
            dataPipe_d[0] = timerVal;
        end else if (dataInRange) begin
            dataPipe_d[0] = mem_q[dataIdx];
        end
        for (int s = 1; s < RD_LATENCY; s++) begin
            instPipe_d[s] = instPipe_q[s-1];
            dataPipe_d[s] = dataPipe_q[s-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < RD_LATENCY; s++) begin
                instPipe_q[s] <= '0;
                dataPipe_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < RD_LATENCY; s++) begin
                instPipe_q[s] <= instPipe_d[s];
                dataPipe_q[s] <= dataPipe_d[s];
            end
        end
    end

    logic addrErr_q;
    logic addrErr_d;
    logic instWeErr_q;
    logic instWeErr_d;

    always_comb begin
        addrErr_d   = addrErr_q | !instInRange | (!dataInRange && !timerHit);
        instWeErr_d = instWeErr_q | sram.inst_sram_we;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addrErr_q   <= 1'b0;
            instWeErr_q <= 1'b0;
        end else begin
            addrErr_q   <= addrErr_d;
            instWeErr_q <= instWeErr_d;
        end
    end

    assign sram.inst_sram_rdata = instPipe_q[RD_LATENCY-1];
    assign sram.data_sram_rdata = dataPipe_q[RD_LATENCY-1];
    assign sram.addr_err        = addrErr_q;
    assign sram.inst_we_err     = instWeErr_q;

endmodule

// File: tb/tb_sram_responder.sv
// Scoreboard bench for sram_responder: one stimulus stream drives a latency-1 and a latency-3 instance;
// expected responses are queued at issue and popped by an independent monitor.
module tb_sram_responder;

    localparam logic [31:0] BASE  = 32'h1c00_0000;
    localparam logic [31:0] TADDR = 32'hbfaf_e000;
    localparam logic [31:0] IDLE  = 32'h1c00_0f00;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    sram_responder_if bus1();
    sram_responder_if bus3();

    sram_responder #(.RD_LATENCY(1)) dutL1 (.clk(clk), .reset(reset), .sram(bus1));
    sram_responder #(.RD_LATENCY(3)) dutL3 (.clk(clk), .reset(reset), .sram(bus3));

    typedef struct {
        bit          chkI;
        logic [31:0] expI;
        bit          chkD;
        logic [31:0] expD;
    } rdExp_t;

    typedef struct {
        bit addrErr;
        bit instWeErr;
    } flagExp_t;

    rdExp_t      q1[$];
    rdExp_t      q3[$];
    flagExp_t    fq[$];
    logic [31:0] model [int unsigned];
    logic [31:0] timerModel = 32'h0;
    bit          eAddr = 1'b0;
    bit          eInst = 1'b0;
    int          nAsserts = 0;
    int          nFails = 0;

    function automatic bit inRange(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off < 32'h0001_0000;
    endfunction

    function automatic int unsigned wordKey(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'(off >> 2);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nAsserts++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; expected responses come from the bench's own storage/timer model.
    task automatic applyStimulus(input bit rst, input bit iwe, input logic [31:0] iaddr,
                                 input bit dwe, input logic [31:0] daddr, input logic [31:0] dwdata);
        rdExp_t   e;
        flagExp_t f;
        bit       dTimer;
        @(negedge clk);
        reset = rst;
        bus1.inst_sram_we = iwe;  bus3.inst_sram_we = iwe;
        bus1.inst_sram_addr = iaddr;  bus3.inst_sram_addr = iaddr;
        bus1.inst_sram_wdata = 32'h5a5a_0000 ^ dwdata;  bus3.inst_sram_wdata = 32'h5a5a_0000 ^ dwdata;
        bus1.data_sram_we = dwe;  bus3.data_sram_we = dwe;
        bus1.data_sram_addr = daddr;  bus3.data_sram_addr = daddr;
        bus1.data_sram_wdata = dwdata;  bus3.data_sram_wdata = dwdata;
        e = '{1'b1, 32'h0, 1'b1, 32'h0};
        if (rst) begin
            foreach (q1[k]) q1[k] = '{1'b1, 32'h0, 1'b1, 32'h0};
            foreach (q3[k]) q3[k] = '{1'b1, 32'h0, 1'b1, 32'h0};
            eAddr = 1'b0;
            eInst = 1'b0;
            timerModel = 32'h0;
        end else begin
            dTimer = 1'b0;
`ifdef SRAM_TIMER_EN
            dTimer = (daddr == TADDR);
            timerModel = (dTimer && dwe) ? dwdata : timerModel + 32'd1;
`endif
            if (inRange(iaddr)) begin
                e.chkI = model.exists(wordKey(iaddr)) != 0;
                e.expI = e.chkI ? model[wordKey(iaddr)] : 32'h0;
            end else begin
                eAddr = 1'b1;
            end
            if (iwe) eInst = 1'b1;
            if (dTimer) begin
                e.expD = timerModel;
            end else if (inRange(daddr)) begin
                e.chkD = model.exists(wordKey(daddr)) != 0;
                e.expD = e.chkD ? model[wordKey(daddr)] : 32'h0;
                if (dwe) model[wordKey(daddr)] = dwdata;
            end else begin
                eAddr = 1'b1;
            end
        end
        f = '{eAddr, eInst};
        q1.push_back(e);
        q3.push_back(e);
        fq.push_back(f);
    endtask

    rdExp_t   monE;
    flagExp_t monF;

    // Each entry is retired once its instance's read latency has elapsed.
    always begin
        @(posedge clk);
        #1;
        if (fq.size() >= 1) begin
            monF = fq.pop_front();
            checkOutput("addr_err L1", {31'b0, bus1.addr_err}, {31'b0, monF.addrErr});
            checkOutput("inst_we_err L1", {31'b0, bus1.inst_we_err}, {31'b0, monF.instWeErr});
            checkOutput("addr_err L3", {31'b0, bus3.addr_err}, {31'b0, monF.addrErr});
            checkOutput("inst_we_err L3", {31'b0, bus3.inst_we_err}, {31'b0, monF.instWeErr});
        end
        if (q1.size() >= 1) begin
            monE = q1.pop_front();
            if (monE.chkI) checkOutput("inst_rdata L1", bus1.inst_sram_rdata, monE.expI);
            if (monE.chkD) checkOutput("data_rdata L1", bus1.data_sram_rdata, monE.expD);
        end
        if (q3.size() >= 3) begin
            monE = q3.pop_front();
            if (monE.chkI) checkOutput("inst_rdata L3", bus3.inst_sram_rdata, monE.expI);
            if (monE.chkD) checkOutput("data_rdata L3", bus3.data_sram_rdata, monE.expD);
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b1;
        bus1.inst_sram_we = 1'b0;  bus3.inst_sram_we = 1'b0;
        bus1.inst_sram_addr = IDLE;  bus3.inst_sram_addr = IDLE;
        bus1.inst_sram_wdata = 32'h0;  bus3.inst_sram_wdata = 32'h0;
        bus1.data_sram_we = 1'b0;  bus3.data_sram_we = 1'b0;
        bus1.data_sram_addr = IDLE;  bus3.data_sram_addr = IDLE;
        bus1.data_sram_wdata = 32'h0;  bus3.data_sram_wdata = 32'h0;

        applyStimulus(1, 0, IDLE, 0, IDLE, 0);
        applyStimulus(1, 0, IDLE, 0, IDLE, 0);

        // Basic write then read on both ports.
        applyStimulus(0, 0, IDLE, 1, BASE + 32'h10, 32'hdead_beef);
        applyStimulus(0, 0, BASE + 32'h10, 0, BASE + 32'h10, 0);
        applyStimulus(0, 0, IDLE, 0, IDLE, 0);

        // Read-before-write on a shared index.
        applyStimulus(0, 0, IDLE, 1, BASE + 32'h20, 32'h1111_1111);
        applyStimulus(0, 0, BASE + 32'h20, 1, BASE + 32'h20, 32'h2222_2222);
        applyStimulus(0, 0, BASE + 32'h20, 0, BASE + 32'h20, 0);

        // Back-to-back reads across words 0..3, opposite orders on the two ports.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, IDLE, 1, BASE + 32'(4 * i), 32'h0000_00a0 + 32'(i));
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, BASE + 32'(4 * i), 0, BASE + 32'h0c - 32'(4 * i), 0);
        end

        // Last in-range word, addressed with nonzero low bits on the read.
        applyStimulus(0, 0, IDLE, 1, BASE + 32'h0000_fffc, 32'h7777_0077);
        applyStimulus(0, 0, BASE + 32'h0000_ffff, 0, BASE + 32'h0000_fffd, 0);

        // Out of range below base and just past the top; word 0 must stay intact.
        applyStimulus(0, 0, BASE - 32'h4, 0, IDLE, 0);
        applyStimulus(0, 0, IDLE, 1, BASE + 32'h0001_0000, 32'h5);
        applyStimulus(0, 0, BASE, 0, BASE + 32'h0001_0000, 0);
        applyStimulus(0, 0, IDLE, 0, BASE, 0);
        applyStimulus(1, 0, IDLE, 0, IDLE, 0);
        applyStimulus(0, 0, IDLE, 0, IDLE, 0);

        // Reset mid-flight, with an uncommitted write in the reset cycle.
        applyStimulus(0, 0, BASE + 32'h10, 0, BASE + 32'h0c, 0);
        applyStimulus(1, 0, IDLE, 1, BASE + 32'h10, 32'h1234_5678);
        applyStimulus(0, 0, IDLE, 0, IDLE, 0);
        applyStimulus(0, 0, BASE + 32'h10, 0, BASE + 32'h10, 0);

        // Illegal instruction-port write.
        applyStimulus(0, 1, BASE + 32'h10, 0, BASE + 32'h20, 0);
        applyStimulus(0, 0, BASE + 32'h10, 0, BASE + 32'h10, 0);

        // Timer address: a counter read when enabled, an out-of-range read otherwise.
        applyStimulus(1, 0, IDLE, 0, IDLE, 0);
        for (int i = 0; i < 9; i++) applyStimulus(0, 0, IDLE, 0, IDLE, 0);
        applyStimulus(0, 0, IDLE, 0, TADDR, 0);
        applyStimulus(0, 0, IDLE, 1, TADDR, 32'hffff_fffe);
        applyStimulus(0, 0, IDLE, 0, TADDR, 0);
        applyStimulus(0, 0, IDLE, 0, TADDR, 0);
        applyStimulus(0, 0, TADDR, 0, IDLE, 0);

        for (int i = 0; i < 4; i++) applyStimulus(0, 0, IDLE, 0, IDLE, 0);
        @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
